// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt controller.
// INT_NEST_EN selects nested service (3-deep level stack) over single-level service.
package int_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SERVE = 2'd2
    } state_t;

    localparam int N_SRC = 3;

    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
    localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;

`ifdef INT_NEST_EN
    localparam int STK_DEPTH = 3;
`else
    localparam int STK_DEPTH = 1;
`endif

endpackage

// File: rtl/int_ctrl_if.sv
// CP0/pipeline-facing signal bundle of the interrupt controller.
// master drives the request inputs and ack/eret; slave is the controller itself.
interface int_ctrl_if;
    import int_pkg::*;

    logic [N_SRC-1:0] in_irq;
    logic             in_IE;
    logic [N_SRC-1:0] in_INM;
    logic             in_ack;
    logic             in_eret;
    logic             out_int_req;
    logic [31:0]      out_vector;
    logic [1:0]       out_level;
    logic [N_SRC-1:0] out_pending;
    state_t           dbg_state;

    modport master (
        output in_irq, in_IE, in_INM, in_ack, in_eret,
        input  out_int_req, out_vector, out_level, out_pending, dbg_state
    );

    modport slave (
        input  in_irq, in_IE, in_INM, in_ack, in_eret,
        output out_int_req, out_vector, out_level, out_pending, dbg_state
    );
endinterface

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder over the eligible sources; bit 2 wins.
module int_prio_enc
    import int_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [1:0]       idx
);
    always_comb begin
        valid = |req;
        idx   = 2'd0;
        if (req[2])      idx = 2'd2;
        else if (req[1]) idx = 2'd1;
    end
endmodule

// File: rtl/int_ctrl.sv
// Edge-triggered 3-source interrupt controller with prioritised vectoring.
// INT_NEST_EN enables preemption by higher sources via a 3-deep level stack.
module int_ctrl
    import int_pkg::*;
#(
    parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
    parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic      in_clk,
    input  logic      in_RST,
    int_ctrl_if.slave bus
);
    // Handshake: out_int_req holds while in REQ; in_ack and in_eret are single-cycle
    // pulses, in_ack only counts in REQ, in_eret only when a level is stacked.
    state_t           state_q, state_d, prior_q, prior_d;
    logic [1:0]       sel_q, sel_d, level_q, level_d, sp_q, sp_d, pop_lvl;
    logic [N_SRC-1:0] irq_q, irq_prev_q, pend_q, pend_d, rise, clr, elig;
    logic             enc_valid;
    logic [1:0]       enc_idx;
`ifdef INT_NEST_EN
    logic [STK_DEPTH-1:0][1:0] stk_q, stk_d;
`endif

    int_prio_enc u_prio (
        .req   (elig),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    always_comb begin
        rise = irq_q & ~irq_prev_q;
        for (int i = 0; i < N_SRC; i++)
            elig[i] = pend_q[i] & ~bus.in_INM[i] & bus.in_IE & ((i + 1) > int'(level_q));
`ifdef INT_NEST_EN
        pop_lvl = (sp_q != 2'd0) ? stk_q[sp_q - 2'd1] : 2'd0;
        stk_d   = stk_q;
`else
        if (state_q == SERVE) elig = '0;
        pop_lvl = 2'd0;
`endif
        state_d = state_q;
        prior_d = prior_q;
        sel_d   = sel_q;
        level_d = level_q;
        sp_d    = sp_q;
        clr     = '0;

        case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    state_d = REQ;
                    sel_d   = enc_idx;
                    prior_d = IDLE;
                end
            end
            SERVE: begin
                if (bus.in_eret && sp_q != 2'd0) begin
                    level_d = pop_lvl;
                    sp_d    = sp_q - 2'd1;
                    if (pop_lvl == 2'd0) state_d = IDLE;
                end else if (enc_valid) begin
                    state_d = REQ;
                    sel_d   = enc_idx;
                    prior_d = SERVE;
                end
            end
            REQ: begin
                if (bus.in_ack) begin
                    clr[sel_q] = 1'b1;
                    state_d    = SERVE;
                    level_d    = sel_q + 2'd1;
                    sp_d       = sp_q + 2'd1;
`ifdef INT_NEST_EN
                    stk_d[sp_q] = level_q;
`endif
                    // A coincident eret pops the entry just pushed.
                    if (bus.in_eret) begin
`ifdef INT_NEST_EN
                        level_d = level_q;
                        sp_d    = sp_q;
`else
                        level_d = 2'd0;
                        sp_d    = 2'd0;
                        state_d = IDLE;
`endif
                    end
                end else if (bus.in_eret && sp_q != 2'd0) begin
                    level_d = pop_lvl;
                    sp_d    = sp_q - 2'd1;
                    if (pop_lvl == 2'd0) prior_d = IDLE;
                end else if (!elig[sel_q]) begin
                    state_d = prior_q;
                end
            end
            default: state_d = IDLE;
        endcase

        pend_d = (pend_q & ~clr) | rise;
    end

    always_ff @(posedge in_clk or negedge in_RST) begin
        if (!in_RST) begin
            state_q    <= IDLE;
            prior_q    <= IDLE;
            sel_q      <= 2'd0;
            level_q    <= 2'd0;
            sp_q       <= 2'd0;
            pend_q     <= '0;
            irq_q      <= '0;
            irq_prev_q <= '0;
`ifdef INT_NEST_EN
            stk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            prior_q    <= prior_d;
            sel_q      <= sel_d;
            level_q    <= level_d;
            sp_q       <= sp_d;
            pend_q     <= pend_d;
            irq_q      <= bus.in_irq;
            irq_prev_q <= irq_q;
`ifdef INT_NEST_EN
            stk_q      <= stk_d;
`endif
        end
    end

    assign bus.out_int_req = (state_q == REQ);
    assign bus.out_vector  = VEC_BASE + 32'(sel_q) * VEC_STRIDE;
    assign bus.out_level   = level_q;
    assign bus.out_pending = pend_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_int_ctrl.sv
// Directed table-driven bench for int_ctrl; the INT_NEST_EN build adds the nesting sequences.
module tb_int_ctrl;
    import int_pkg::*;

    typedef struct {
        logic [2:0]  irq;
        logic        ie;
        logic [2:0]  inm;
        logic        ack;
        logic        eret;
        logic        exp_req;
        logic [31:0] exp_vec;
        logic [1:0]  exp_lvl;
        logic [2:0]  exp_pend;
    } vec_t;

    logic in_clk;
    logic in_RST;
    int   n_vec;
    int   n_err;
    vec_t tbl[25];

    int_ctrl_if bus();

    int_ctrl #(
        .VEC_BASE   (32'h0000_0100),
        .VEC_STRIDE (32'h0000_0010)
    ) dut (
        .in_clk (in_clk),
        .in_RST (in_RST),
        .bus    (bus)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    function automatic vec_t mk(input logic [2:0] irq, input logic ie, input logic [2:0] inm,
                                input logic ack, input logic eret, input logic req,
                                input logic [31:0] vec, input logic [1:0] lvl, input logic [2:0] pend);
        vec_t v;
        v.irq = irq; v.ie = ie; v.inm = inm; v.ack = ack; v.eret = eret;
        v.exp_req = req; v.exp_vec = vec; v.exp_lvl = lvl; v.exp_pend = pend;
        return v;
    endfunction

    task automatic check(input string name, input logic req, input logic [31:0] vec,
                         input logic [1:0] lvl, input logic [2:0] pend);
        n_vec++;
        if (bus.out_int_req !== req || bus.out_vector !== vec ||
            bus.out_level !== lvl || bus.out_pending !== pend) begin
            n_err++;
            $display("FAIL %s: got req=%0b vec=%h lvl=%0d pend=%b, expected req=%0b vec=%h lvl=%0d pend=%b",
                     name, bus.out_int_req, bus.out_vector, bus.out_level, bus.out_pending,
                     req, vec, lvl, pend);
        end
    endtask

    task automatic check_state(input string name, input state_t exp);
        n_vec++;
        if (bus.dbg_state !== exp) begin
            n_err++;
            $display("FAIL %s: got state=%0d, expected state=%0d", name, bus.dbg_state, exp);
        end
    endtask

    // Called at a negedge: drive, clock once, sample at the following negedge.
    task automatic run_vec(input vec_t v, input string name);
        bus.in_irq  = v.irq;
        bus.in_IE   = v.ie;
        bus.in_INM  = v.inm;
        bus.in_ack  = v.ack;
        bus.in_eret = v.eret;
        @(posedge in_clk);
        @(negedge in_clk);
        check(name, v.exp_req, v.exp_vec, v.exp_lvl, v.exp_pend);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        //          irq    ie  inm    ack  eret  req  vector       lvl  pend
        tbl[0]  = mk(3'b000, 1, 3'b000, 0, 0,   0, 32'h100, 0, 3'b000);
        tbl[1]  = mk(3'b010, 1, 3'b000, 0, 0,   0, 32'h100, 0, 3'b000);
        tbl[2]  = mk(3'b010, 1, 3'b000, 0, 0,   0, 32'h100, 0, 3'b010);
        tbl[3]  = mk(3'b010, 1, 3'b000, 0, 0,   1, 32'h110, 0, 3'b010);
        tbl[4]  = mk(3'b010, 1, 3'b000, 1, 0,   0, 32'h110, 2, 3'b000);
        tbl[5]  = mk(3'b000, 1, 3'b000, 0, 0,   0, 32'h110, 2, 3'b000);
        tbl[6]  = mk(3'b000, 1, 3'b000, 0, 1,   0, 32'h110, 0, 3'b000);
        tbl[7]  = mk(3'b101, 1, 3'b000, 0, 0,   0, 32'h110, 0, 3'b000);
        tbl[8]  = mk(3'b101, 1, 3'b000, 0, 0,   0, 32'h110, 0, 3'b101);
        tbl[9]  = mk(3'b101, 1, 3'b000, 0, 0,   1, 32'h120, 0, 3'b101);
        tbl[10] = mk(3'b101, 1, 3'b000, 1, 0,   0, 32'h120, 3, 3'b001);
        tbl[11] = mk(3'b101, 1, 3'b000, 0, 0,   0, 32'h120, 3, 3'b001);
        tbl[12] = mk(3'b101, 1, 3'b000, 0, 1,   0, 32'h120, 0, 3'b001);
        tbl[13] = mk(3'b101, 1, 3'b000, 0, 0,   1, 32'h100, 0, 3'b001);
        tbl[14] = mk(3'b101, 1, 3'b000, 1, 0,   0, 32'h100, 1, 3'b000);
        tbl[15] = mk(3'b101, 1, 3'b000, 0, 1,   0, 32'h100, 0, 3'b000);
        tbl[16] = mk(3'b000, 1, 3'b000, 1, 0,   0, 32'h100, 0, 3'b000);
        tbl[17] = mk(3'b000, 1, 3'b000, 0, 1,   0, 32'h100, 0, 3'b000);
        tbl[18] = mk(3'b010, 1, 3'b000, 0, 0,   0, 32'h100, 0, 3'b000);
        tbl[19] = mk(3'b010, 1, 3'b000, 0, 0,   0, 32'h100, 0, 3'b010);
        tbl[20] = mk(3'b010, 1, 3'b000, 0, 0,   1, 32'h110, 0, 3'b010);
        tbl[21] = mk(3'b010, 1, 3'b010, 0, 0,   0, 32'h110, 0, 3'b010);
        tbl[22] = mk(3'b010, 1, 3'b010, 0, 0,   0, 32'h110, 0, 3'b010);
        tbl[23] = mk(3'b010, 1, 3'b000, 0, 0,   1, 32'h110, 0, 3'b010);
        tbl[24] = mk(3'b010, 1, 3'b000, 1, 0,   0, 32'h110, 2, 3'b000);

        in_RST      = 1'b0;
        bus.in_irq  = 3'b000;
        bus.in_IE   = 1'b0;
        bus.in_INM  = 3'b000;
        bus.in_ack  = 1'b0;
        bus.in_eret = 1'b0;
        repeat (2) @(negedge in_clk);
        check("reset", 1'b0, 32'h100, 2'd0, 3'b000);
        check_state("reset_state", IDLE);
        in_RST = 1'b1;

        for (int i = 0; i < 25; i++)
            run_vec(tbl[i], $sformatf("tbl[%0d]", i));
        check_state("withdrawn_then_served", SERVE);

`ifdef INT_NEST_EN
        run_vec(mk(3'b110, 1, 3'b000, 0, 0, 0, 32'h110, 2, 3'b000), "nest_a");
        run_vec(mk(3'b110, 1, 3'b000, 0, 0, 0, 32'h110, 2, 3'b100), "nest_b");
        run_vec(mk(3'b110, 1, 3'b000, 0, 0, 1, 32'h120, 2, 3'b100), "nest_preempt_req");
        run_vec(mk(3'b110, 1, 3'b000, 1, 0, 0, 32'h120, 3, 3'b000), "nest_ack");
        run_vec(mk(3'b110, 1, 3'b000, 0, 1, 0, 32'h120, 2, 3'b000), "nest_eret1");
        check_state("nest_eret1_state", SERVE);
        run_vec(mk(3'b110, 1, 3'b000, 0, 1, 0, 32'h120, 0, 3'b000), "nest_eret2");
        check_state("nest_eret2_state", IDLE);
        run_vec(mk(3'b000, 1, 3'b000, 0, 0, 0, 32'h120, 0, 3'b000), "coinc_a");
        run_vec(mk(3'b100, 1, 3'b000, 0, 0, 0, 32'h120, 0, 3'b000), "coinc_b");
        run_vec(mk(3'b100, 1, 3'b000, 0, 0, 0, 32'h120, 0, 3'b100), "coinc_c");
        run_vec(mk(3'b100, 1, 3'b000, 0, 0, 1, 32'h120, 0, 3'b100), "coinc_req");
        run_vec(mk(3'b100, 1, 3'b000, 1, 1, 0, 32'h120, 0, 3'b000), "coinc_ack_eret");
        check_state("coinc_state", SERVE);
`else
        run_vec(mk(3'b110, 1, 3'b000, 0, 0, 0, 32'h110, 2, 3'b000), "flat_a");
        run_vec(mk(3'b110, 1, 3'b000, 0, 0, 0, 32'h110, 2, 3'b100), "flat_b");
        run_vec(mk(3'b110, 1, 3'b000, 0, 0, 0, 32'h110, 2, 3'b100), "flat_held");
        check_state("flat_held_state", SERVE);
        run_vec(mk(3'b110, 1, 3'b000, 0, 1, 0, 32'h110, 0, 3'b100), "flat_eret");
        run_vec(mk(3'b110, 1, 3'b000, 0, 0, 1, 32'h120, 0, 3'b100), "flat_req");
        run_vec(mk(3'b110, 1, 3'b000, 1, 0, 0, 32'h120, 3, 3'b000), "flat_ack");
        run_vec(mk(3'b110, 1, 3'b000, 0, 1, 0, 32'h120, 0, 3'b000), "flat_eret2");
        check_state("flat_eret2_state", IDLE);
`endif

        // Clean restart, then build up SERVE at level 2 with sources 0 and 2 pending.
        bus.in_irq  = 3'b000;
        bus.in_ack  = 1'b0;
        bus.in_eret = 1'b0;
        in_RST      = 1'b0;
        @(negedge in_clk);
        in_RST = 1'b1;
        run_vec(mk(3'b010, 1, 3'b000, 0, 0, 0, 32'h100, 0, 3'b000), "rst_a");
        run_vec(mk(3'b010, 1, 3'b000, 0, 0, 0, 32'h100, 0, 3'b010), "rst_b");
        run_vec(mk(3'b010, 1, 3'b000, 0, 0, 1, 32'h110, 0, 3'b010), "rst_c");
        run_vec(mk(3'b010, 1, 3'b000, 1, 0, 0, 32'h110, 2, 3'b000), "rst_d");
        run_vec(mk(3'b111, 1, 3'b100, 0, 0, 0, 32'h110, 2, 3'b000), "rst_e");
        run_vec(mk(3'b111, 1, 3'b100, 0, 0, 0, 32'h110, 2, 3'b101), "rst_f");
        check_state("rst_pre_state", SERVE);
        #2;
        in_RST = 1'b0;
        #1;
        check("async_reset", 1'b0, 32'h100, 2'd0, 3'b000);
        check_state("async_reset_state", IDLE);
        @(negedge in_clk);
        bus.in_irq = 3'b000;
        @(negedge in_clk);
        in_RST = 1'b1;
        run_vec(mk(3'b000, 1, 3'b000, 0, 0, 0, 32'h100, 0, 3'b000), "post_rst_a");
        run_vec(mk(3'b000, 1, 3'b000, 0, 0, 0, 32'h100, 0, 3'b000), "post_rst_b");
        check_state("post_rst_state", IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter VEC_BASE, default 32'h0000_0100, SHALL be the word address of the source-0 handler.
REQ-002 Parameter VEC_STRIDE, default 32'h0000_0010, SHALL be the word-address spacing between handler vectors.
REQ-003 in_clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 in_RST  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 in_irq  input  3  SHALL carry the interrupt sources; a rising edge is a request; bit 2 has highest priority.
REQ-006 in_IE  input  1  SHALL be the global interrupt enable from CP0.
REQ-007 in_INM  input  3  SHALL be the per-source mask from CP0; 1 = masked.
REQ-008 in_ack  input  1  SHALL be the pipeline's one-cycle pulse that the vector was taken and EPC saved.
REQ-009 in_eret  input  1  SHALL be the one-cycle pulse marking return from the current handler.
REQ-010 out_int_req  output  1  SHALL request the PC mux to redirect to out_vector.
REQ-011 out_vector  output  32  SHALL be VEC_BASE + sel*VEC_STRIDE, where sel is the latched source index.
REQ-012 out_level  output  2  SHALL be the current service level: 0 = none, 1..3 = source 0..2.
REQ-013 out_pending  output  3  SHALL be the pending-request register.

Function
REQ-014 Edge detect: a 0->1 transition of in_irq[i], sampled at edge N, SHALL set pend[i] at edge N+1.
REQ-015 pend[i] SHALL clear on in_ack when sel==i.
REQ-016 When a new edge for source i arrives in the same cycle as the clear for i, the set SHALL win.
REQ-017 Eligibility: elig[i] = pend[i] & ~in_INM[i] & in_IE & (i+1 > out_level).
REQ-018 FSM states SHALL be IDLE, REQ and SERVE.
REQ-019 IDLE->REQ or SERVE->REQ SHALL occur on the edge where elig!=0; sel SHALL latch the highest eligible index and freeze while in REQ.
REQ-020 In REQ, out_int_req SHALL be 1; in all other states it SHALL be 0.
REQ-021 Latency: an irq edge at cycle N SHALL assert out_int_req at cycle N+2 when the source is eligible.
REQ-022 REQ->SERVE on in_ack SHALL push out_level onto a 3-deep level stack and set out_level=sel+1.
REQ-023 REQ withdrawal: if elig[sel] falls before in_ack (masked or IE cleared), the FSM SHALL return to its prior state (IDLE or SERVE) with pend kept.
REQ-024 in_eret in SERVE or REQ SHALL pop the stack into out_level; the FSM SHALL go to IDLE when the popped level is 0 and the state is SERVE.
REQ-025 in_eret with an empty stack SHALL be ignored.
REQ-026 in_ack outside REQ SHALL be ignored.
REQ-027 When in_ack and in_eret coincide in REQ, in_ack SHALL take effect first; the eret SHALL then pop the level just pushed, leaving the net level unchanged and the state at SERVE.

Reset
REQ-028 While in_RST=0: state=IDLE, pend=0, stack empty, out_level=0, out_int_req=0, out_vector=VEC_BASE, out_pending=0, edge-detect history=0.
REQ-029 Reset mid-service SHALL discard all pending and stacked levels without generating any request.

Configuration
REQ-030 Macro INT_NEST_EN defined: nesting SHALL follow REQ-017 and REQ-019, with stack depth 3.
REQ-031 Macro INT_NEST_EN undefined: elig SHALL be 0 whenever state is SERVE, the stack SHALL be 1 deep, and in_eret SHALL return directly to IDLE with out_level=0.

Structure
REQ-032 The shared package int_pkg SHALL hold the FSM state typedef (IDLE/REQ/SERVE), the source count constant 3, and the default VEC_BASE/VEC_STRIDE.
REQ-033 Sub-module int_prio_enc SHALL implement the 3-bit priority encoder (elig -> valid, index).

Verification
REQ-034 Single request: IE=1, INM=0, irq[1] rises at cycle 5 -> out_int_req=1 at cycle 7, out_vector=32'h110; in_ack -> out_level=2, pend[1]=0.
REQ-035 Priority: irq[0] and irq[2] rise together -> sel=2, out_vector=32'h120; after ack and eret, source 0 is served with out_vector=32'h100.
REQ-036 Nesting (INT_NEST_EN defined): serving level 1, irq[2] rises -> request fires, ack makes out_level=3, eret returns out_level=1, second eret gives 0 and IDLE.
REQ-037 Withdrawal: in REQ for source 1, INM[1] set before ack -> out_int_req=0 the next cycle, pend[1] stays 1; clearing INM[1] re-requests.
REQ-038 Reset mid-SERVE at level 2 with pend=3'b101 -> all outputs take their reset values immediately (asynchronously).
REQ-039 Without INT_NEST_EN: irq[2] arriving during level-1 service stays pending until eret, then is served.
